// File: rtl/md5_pkg.sv
// Shared MD5 definitions: padder state encoding, padding constants and accelerator IVs.
package md5_pkg;

    typedef enum logic [2:0] {
        StClear,
        StLoad,
        StDrain,
        StPad,
        StStart,
        StWait
    } pad_state_e;

    localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;
    localparam int unsigned MD5_BLOCK_WORDS = 16;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

endpackage

// File: rtl/md5_block_buf.sv
// 16x32 message block register file: byte-lane and word-pair writes, synchronous clear,
// combinational read.
module md5_block_buf
    import md5_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_we,
    input  logic [5:0]  byte_idx,
    input  logic [7:0]  byte_data,
    input  logic        word_we,
    input  logic [2:0]  word_pair,
    input  logic [63:0] word_data,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem_q [MD5_BLOCK_WORDS];

    // Word writes cover an aligned pair so the 64-bit little-endian length lands in one go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MD5_BLOCK_WORDS; i++) mem_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < MD5_BLOCK_WORDS; i++) mem_q[i] <= '0;
        end else begin
            if (byte_we) begin
                mem_q[byte_idx[5:2]][{byte_idx[1:0], 3'b000} +: 8] <= byte_data;
            end
            if (word_we) begin
                mem_q[{word_pair, 1'b0}] <= word_data[31:0];
                mem_q[{word_pair, 1'b1}] <= word_data[63:32];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/md5_msg_padder.sv
// Single-block MD5 front end: collects a byte stream, pads it into a 512-bit block and
// serves the accelerator's word reads until the digest has been delivered.
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN = 55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        in_ready,
    input  logic [3:0]  messageAddress,
    input  logic        mem_read,
    output logic [31:0] messageChunk,
    output logic        start,
    input  logic        hash_valid,
    output logic        busy,
    output logic        length_error
);

    localparam int unsigned LenW = 6;
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);

    pad_state_e      state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic            hash_valid_q, hash_valid_d;
    logic            len_err_q, len_err_d;

    logic            buf_clear;
    logic            byte_we;
    logic [7:0]      byte_data;
    logic            word_we;
    logic [63:0]     word_data;

    // Reads are unconditional; the strobe carries no information for the buffer.
    logic unused_mem_read;
    assign unused_mem_read = mem_read;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hash_valid_d = 1'b0;
        len_err_d    = 1'b0;
        buf_clear    = 1'b0;
        byte_we      = 1'b0;
        byte_data    = in_data;
        word_we      = 1'b0;
        in_ready     = 1'b0;
        start        = 1'b0;
        busy         = 1'b0;

        unique case (state_q)
            StClear: begin
                buf_clear = 1'b1;
                len_d     = '0;
                state_d   = StLoad;
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last) begin
                        if (in_empty) begin
                            state_d = StPad;
                        end else if (len_q == MaxLen) begin
                            len_err_d = 1'b1;
                            state_d   = StClear;
                        end else begin
                            byte_we = 1'b1;
                            len_d   = len_q + 1'b1;
                            state_d = StPad;
                        end
                    end else if (!in_empty) begin
                        // A full buffer plus another non-final byte can only end in error.
                        if (len_q == MaxLen) begin
                            state_d = StDrain;
                        end else begin
                            byte_we = 1'b1;
                            len_d   = len_q + 1'b1;
                        end
                    end
                end
            end
            StDrain: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    len_err_d = 1'b1;
                    state_d   = StClear;
                end
            end
            StPad: begin
                byte_we   = 1'b1;
                byte_data = MD5_PAD_BYTE;
                word_we   = 1'b1;
                state_d   = StStart;
            end
            StStart: begin
                start   = 1'b1;
                busy    = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                busy         = 1'b1;
                hash_valid_d = hash_valid;
                if (hash_valid_q && !hash_valid) state_d = StClear;
            end
            default: state_d = StClear;
        endcase
    end

    // Bit length occupies words 14 (low) and 15 (high, always zero here).
    assign word_data = {55'd0, len_q, 3'b000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StClear;
            len_q        <= '0;
            hash_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hash_valid_q <= hash_valid_d;
            len_err_q    <= len_err_d;
        end
    end

    assign length_error = len_err_q;

    md5_block_buf u_block_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (buf_clear),
        .byte_we   (byte_we),
        .byte_idx  (len_q),
        .byte_data (byte_data),
        .word_we   (word_we),
        .word_pair (3'd7),
        .word_data (word_data),
        .rd_addr   (messageAddress),
        .rd_data   (messageChunk)
    );

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: a byte-array padding model fills a scoreboard of
// expected block words, compared against messageChunk reads once start has pulsed.
module tb_md5_msg_padder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        in_ready;
    logic [3:0]  messageAddress = '0;
    logic        mem_read = 1'b0;
    logic [31:0] messageChunk;
    logic        start;
    logic        hash_valid = 1'b0;
    logic        busy;
    logic        length_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  msg[$];

    md5_msg_padder #(.MAX_LEN(55)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_empty       (in_empty),
        .in_ready       (in_ready),
        .messageAddress (messageAddress),
        .mem_read       (mem_read),
        .messageChunk   (messageChunk),
        .start          (start),
        .hash_valid     (hash_valid),
        .busy           (busy),
        .length_error   (length_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference padding: message bytes, 0x80, zero fill, 64-bit LE bit count.
    task automatic push_expected();
        logic [7:0]  blk [64];
        logic [63:0] bits;
        int n;
        n = msg.size();
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < n; i++) blk[i] = msg[i];
        blk[n] = 8'h80;
        bits = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) blk[56+k] = bits[8*k +: 8];
        for (int w = 0; w < 16; w++)
            exp_q.push_back({blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});
    endtask

    task automatic push_zero_block();
        for (int w = 0; w < 16; w++) exp_q.push_back(32'h0);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        check("accept_in_time", 64'(done), 64'd1);
    endtask

    task automatic check_block(input string tag);
        check({tag, "_sb_depth"}, 64'(exp_q.size() >= 16), 64'd1);
        for (int a = 0; a < 16; a++) begin
            messageAddress = 4'(a);
            #1;
            check($sformatf("%s_w%0d", tag, a), 64'(messageChunk), 64'(exp_q.pop_front()));
        end
        messageAddress = 4'd0;
    endtask

    task automatic run_block(input string tag, input bit empty_last);
        int n;
        n = msg.size();
        push_expected();
        if (empty_last) begin
            for (int i = 0; i < n; i++) send_beat(msg[i], 1'b0, 1'b0);
            send_beat(8'h5a, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++) send_beat(msg[i], i == n - 1, 1'b0);
        end
        @(negedge clk);
        check({tag, "_pad_start"}, 64'(start), 64'd0);
        check({tag, "_pad_lenerr"}, 64'(length_error), 64'd0);
        @(negedge clk);
        check({tag, "_start"}, 64'(start), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_start_lenerr"}, 64'(length_error), 64'd0);
        @(negedge clk);
        check({tag, "_start_once"}, 64'(start), 64'd0);
        check({tag, "_wait_busy"}, 64'(busy), 64'd1);
        check({tag, "_wait_ready"}, 64'(in_ready), 64'd0);
        check_block(tag);
    endtask

    task automatic finish_hash(input string tag);
        @(posedge clk);
        #1 hash_valid = 1'b1;
        @(posedge clk);
        #1 hash_valid = 1'b0;
        @(negedge clk);
        check({tag, "_fall_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_fall_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, "_clear_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_clear_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_load_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_overflow(input string tag, input int n);
        push_zero_block();
        for (int i = 0; i < n; i++) send_beat(8'(i + 1), i == n - 1, 1'b0);
        @(negedge clk);
        check({tag, "_lenerr"}, 64'(length_error), 64'd1);
        check({tag, "_nostart"}, 64'(start), 64'd0);
        check({tag, "_clear_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_lenerr_once"}, 64'(length_error), 64'd0);
        check({tag, "_nostart2"}, 64'(start), 64'd0);
        check({tag, "_load_ready"}, 64'(in_ready), 64'd1);
        check_block(tag);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_lenerr", 64'(length_error), 64'd0);
        check("rst_chunk", 64'(messageChunk), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("first_cycle_clear", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        run_block("abc", 1'b0);
        finish_hash("abc");

        // Zero-length message
        msg.delete();
        run_block("empty", 1'b1);
        finish_hash("empty");

        // Maximum length: 55 x 'A'
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h41);
        run_block("max55", 1'b0);

        // Next message offered while the block is held
        in_data  = 8'h31;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("held_ready_low", 64'(in_ready), 64'd0);
        end
        finish_hash("max55");
        msg = '{8'h31, 8'h32};
        run_block("second", 1'b0);
        finish_hash("second");

        // Over-length messages
        run_overflow("ovf60", 60);
        run_overflow("ovf56", 56);

        // Abort mid-LOAD with reset, then a clean "abc"
        for (int i = 0; i < 10; i++) send_beat(8'h77, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(in_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_start", 64'(start), 64'd0);
        check("abort_lenerr", 64'(length_error), 64'd0);
        check("abort_chunk", 64'(messageChunk), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_clear_ready", 64'(in_ready), 64'd0);
        check("abort_nostart", 64'(start), 64'd0);
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        run_block("abc2", 1'b0);
        finish_hash("abc2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
